// File: rtl/fetch_queue.sv
// Instruction fetch front end: owns the PC, reads the 1-cycle instruction
// memory and queues {instr, pc} pairs for decode behind a valid/ready port.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic [15:0]              im_addr,
  output logic                     im_rd_en,
  input  logic [15:0]              im_instr,
  output logic                     id_valid,
  output logic [15:0]              id_instr,
  output logic [15:0]              id_pc,
  input  logic                     id_ready,
  input  logic                     redirect,
  input  logic [15:0]              redirect_pc,
  input  logic                     halt,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  typedef enum logic {
    RUN,
    HALTED
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [15:0]   pc_q;
  logic          inflight_q;
  logic [15:0]   inflight_pc_q;
  logic [AW-1:0] head_q;
  logic [AW-1:0] tail_q;
  logic [AW:0]   count_q;

  logic [15:0] instr_mem [DEPTH];
  logic [15:0] pc_mem    [DEPTH];

  logic        issue;
  logic        push;
  logic        pop;
  logic [AW:0] credit;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (halt) state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
  end

  assign halted = (state_q == HALTED);

  // Credit counts the in-flight read so a response always has a free slot.
  assign credit = count_q + {{AW{1'b0}}, inflight_q};

  assign issue = !rst
              && (state_q == RUN)
              && !halt
              && !redirect
              && (credit < DEPTH_C);

  assign im_rd_en = issue;
  assign im_addr  = pc_q;

  assign id_valid = (count_q != '0);
  assign push     = inflight_q && !redirect;
  assign pop      = id_valid && id_ready && !redirect;

  // PC and in-flight tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 16'h0000;
    end else if (redirect) begin
      pc_q       <= redirect_pc;
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q          <= pc_q + 16'd1;
        inflight_pc_q <= pc_q;
      end
    end
  end

  // Queue pointers and count
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (redirect) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PTR_ONE;
      if (pop)  head_q <= head_q + PTR_ONE;
      unique case (1'b1)
        push && !pop: count_q <= count_q + CNT_ONE;
        pop && !push: count_q <= count_q - CNT_ONE;
        default:      count_q <= count_q;
      endcase
    end
  end

  // Payload storage needs no reset; count gates visibility.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[tail_q] <= im_instr;
      pc_mem[tail_q]    <= inflight_pc_q;
    end
  end

  assign id_instr  = id_valid ? instr_mem[head_q] : 16'h0000;
  assign id_pc     = id_valid ? pc_mem[head_q]    : 16'h0000;
  assign occupancy = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] im_addr;
  logic        im_rd_en;
  logic [15:0] im_instr;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [15:0] id_pc;
  logic        id_ready;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        halted;
  logic [2:0]  occupancy;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst(rst),
    .im_addr(im_addr), .im_rd_en(im_rd_en), .im_instr(im_instr),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_ready(id_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt),
    .halted(halted), .occupancy(occupancy)
  );

  function automatic logic [15:0] mem_f(input logic [15:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  always @(posedge clk) begin
    if (im_rd_en) im_instr <= mem_f(im_addr);
  end

  typedef struct {
    logic [15:0] instr;
    logic [15:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] m_pc;
  logic [15:0] m_ipc;
  bit          m_infl;
  bit          m_halt;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_issue();
    return !m_halt && !halt && !redirect && (mq.size() + int'(m_infl)) < DEPTH;
  endfunction

  task automatic m_reset();
    mq.delete();
    m_pc   = 16'h0000;
    m_ipc  = 16'h0000;
    m_infl = 0;
    m_halt = 0;
  endtask

  // Drive inputs at the falling edge and compare against the model.
  task automatic apply(input logic r, input logic rd,
                       input logic [15:0] rp, input logic h);
    id_ready    = r;
    redirect    = rd;
    redirect_pc = rp;
    halt        = h;
    #1;
    check("rd_en", im_rd_en, m_issue());
    check("addr", im_addr, m_pc);
    check("valid", id_valid, mq.size() != 0);
    check("occ", occupancy, mq.size());
    check("halted", halted, m_halt);
    if (mq.size() != 0) begin
      check("id_pc", id_pc, mq[0].pc);
      check("id_instr", id_instr, mq[0].instr);
    end else begin
      check("id_pc0", id_pc, 0);
      check("id_instr0", id_instr, 0);
    end
  endtask

  task automatic tick();
    bit iss;
    iss = m_issue();
    @(posedge clk);
    if (redirect) begin
      mq.delete();
      m_infl = 0;
      m_pc   = redirect_pc;
    end else begin
      if (mq.size() != 0 && id_ready) void'(mq.pop_front());
      if (m_infl) mq.push_back('{mem_f(m_ipc), m_ipc});
      m_infl = iss;
      if (iss) begin
        m_ipc = m_pc;
        m_pc  = m_pc + 16'd1;
      end
    end
    if (halt) m_halt = 1;
    @(negedge clk);
  endtask

  task automatic step(input logic r, input logic rd,
                      input logic [15:0] rp, input logic h);
    apply(r, rd, rp, h);
    tick();
  endtask

  // Asserted away from the clock edge to show the clear is asynchronous.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_valid", id_valid, 0);
    check("rst_occ", occupancy, 0);
    check("rst_rd_en", im_rd_en, 0);
    check("rst_halted", halted, 0);
    check("rst_id_pc", id_pc, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
  endtask

  typedef struct {
    logic        rdy;
    logic        rdr;
    logic [15:0] rpc;
    logic        v;
    logic [15:0] pc;
    logic        en;
    logic [15:0] addr;
    logic [2:0]  occ;
  } vec_t;

  vec_t tv[15];

  initial begin
    int got;
    logic [15:0] want;
    bit saw_en;

    tv[0]  = '{1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0};
    tv[1]  = '{1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0001, 0};
    tv[2]  = '{1, 0, 16'h0000, 1, 16'h0000, 1, 16'h0002, 1};
    tv[3]  = '{1, 0, 16'h0000, 1, 16'h0001, 1, 16'h0003, 1};
    tv[4]  = '{1, 1, 16'h0040, 1, 16'h0002, 0, 16'h0004, 1};
    tv[5]  = '{1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0040, 0};
    tv[6]  = '{1, 0, 16'h0000, 0, 16'h0000, 1, 16'h0041, 0};
    tv[7]  = '{1, 0, 16'h0000, 1, 16'h0040, 1, 16'h0042, 1};
    tv[8]  = '{1, 1, 16'hFFFE, 1, 16'h0041, 0, 16'h0043, 1};
    tv[9]  = '{1, 0, 16'h0000, 0, 16'h0000, 1, 16'hFFFE, 0};
    tv[10] = '{1, 0, 16'h0000, 0, 16'h0000, 1, 16'hFFFF, 0};
    tv[11] = '{1, 0, 16'h0000, 1, 16'hFFFE, 1, 16'h0000, 1};
    tv[12] = '{1, 0, 16'h0000, 1, 16'hFFFF, 1, 16'h0001, 1};
    tv[13] = '{1, 0, 16'h0000, 1, 16'h0000, 1, 16'h0002, 1};
    tv[14] = '{1, 0, 16'h0000, 1, 16'h0001, 1, 16'h0003, 1};

    rst = 1'b1;
    id_ready = 1'b0;
    redirect = 1'b0;
    redirect_pc = 16'h0000;
    halt = 1'b0;
    m_reset();
    @(negedge clk);
    check("init_valid", id_valid, 0);
    check("init_rd_en", im_rd_en, 0);
    check("init_occ", occupancy, 0);
    check("init_halted", halted, 0);
    do_reset();

    // Directed table: stream, redirect, PC wrap
    for (int i = 0; i < 15; i++) begin
      apply(tv[i].rdy, tv[i].rdr, tv[i].rpc, 1'b0);
      check($sformatf("tv%0d_valid", i), id_valid, tv[i].v);
      if (tv[i].v) check($sformatf("tv%0d_pc", i), id_pc, tv[i].pc);
      if (tv[i].v) check($sformatf("tv%0d_instr", i), id_instr, mem_f(tv[i].pc));
      check($sformatf("tv%0d_en", i), im_rd_en, tv[i].en);
      check($sformatf("tv%0d_addr", i), im_addr, tv[i].addr);
      check($sformatf("tv%0d_occ", i), occupancy, tv[i].occ);
      tick();
    end

    // Stall: fill to DEPTH, then drain without gaps or repeats
    do_reset();
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
    apply(1'b0, 1'b0, 16'h0, 1'b0);
    check("stall_occ", occupancy, 4);
    check("stall_rd_en", im_rd_en, 0);
    tick();
    got = 0;
    for (int i = 0; i < 20 && got < 8; i++) begin
      apply(1'b1, 1'b0, 16'h0, 1'b0);
      if (id_valid) begin
        want = 16'(got);
        check("stall_seq", id_pc, want);
        got++;
      end
      tick();
    end
    check("stall_cnt", got, 8);

    // Redirect with 3 queued and one read in flight
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
    apply(1'b0, 1'b1, 16'h0040, 1'b0);
    check("rdr_pre_occ", occupancy, 3);
    tick();
    apply(1'b1, 1'b0, 16'h0, 1'b0);
    check("rdr_occ0", occupancy, 0);
    check("rdr_addr", im_addr, 16'h0040);
    tick();
    got = 0;
    for (int i = 0; i < 6 && got == 0; i++) begin
      apply(1'b1, 1'b0, 16'h0, 1'b0);
      if (id_valid) begin
        check("rdr_first_pc", id_pc, 16'h0040);
        got = 1;
      end
      tick();
    end
    check("rdr_seen", got, 1);

    // Halt with 2 queued and one in flight
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
    apply(1'b0, 1'b0, 16'h0, 1'b1);
    check("halt_pre_occ", occupancy, 2);
    tick();
    got = 0;
    saw_en = 0;
    for (int i = 0; i < 8; i++) begin
      apply(1'b1, 1'b0, 16'h0, 1'b0);
      if (im_rd_en) saw_en = 1;
      if (id_valid) begin
        want = 16'(got);
        check("halt_seq", id_pc, want);
        got++;
      end
      tick();
    end
    check("halt_delivered", got, 3);
    check("halt_no_fetch", saw_en, 0);
    check("halt_flag", halted, 1);
    step(1'b1, 1'b1, 16'h0100, 1'b0);
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, 1'b0, 16'h0, 1'b0);
      check("halt_rdr_rd_en", im_rd_en, 0);
      check("halt_rdr_occ", occupancy, 0);
      tick();
    end

    // Reset mid-stream with 3 queued
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 16'h0, 1'b0);
    apply(1'b0, 1'b0, 16'h0, 1'b0);
    check("mid_occ", occupancy, 3);
    do_reset();
    got = 0;
    for (int i = 0; i < 6 && got == 0; i++) begin
      apply(1'b1, 1'b0, 16'h0, 1'b0);
      if (id_valid) begin
        check("mid_restart_pc", id_pc, 16'h0000);
        got = 1;
      end
      tick();
    end
    check("mid_restart_seen", got, 1);

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      if (m_halt && $urandom_range(0, 19) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 9) < 7,
             $urandom_range(0, 29) == 0,
             16'($urandom),
             $urandom_range(0, 199) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
